// File: rtl/legv8_pkg.sv
// LEGv8 issue-stage shared definitions: opcode patterns,
// ALU select encodings and the issue payload bundle.
package legv8_pkg;

    localparam int XLEN = 32;

    // Opcode patterns compared against instr[31:21] under a mask
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_ANDI = 11'b10010010000;
    localparam logic [10:0] OP_ORRI = 11'b10110010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;

    localparam logic [10:0] M_FULL = 11'b11111111111;
    localparam logic [10:0] M_IMM  = 11'b11111111110;
    localparam logic [10:0] M_CBZ  = 11'b11111111000;

    typedef enum logic [1:0] {
        SEL_AND = 2'b00,
        SEL_OR  = 2'b01,
        SEL_ADD = 2'b10,
        SEL_SUB = 2'b11
    } alu_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] alu_a;
        logic [XLEN-1:0] alu_b;
        alu_sel_e        alu_select;
        logic            is_mem;
        logic            is_cbz;
    } issue_t;

    function automatic logic op_hit(
        input logic [10:0] op,
        input logic [10:0] pat,
        input logic [10:0] mask
    );
        return (op & mask) == (pat & mask);
    endfunction

endpackage

// File: rtl/legv8_issue_decode.sv
// Combinational LEGv8 decoder: instruction word plus register
// values to ALU operands, select code and an illegal flag.
module legv8_issue_decode
    import legv8_pkg::*;
(
    input  logic [31:0]   i_instr,
    input  logic [XLEN-1:0] i_rn,
    input  logic [XLEN-1:0] i_rm,
    output issue_t        o_payload,
    output logic          o_illegal
);

    logic [10:0]     w_op;
    logic [XLEN-1:0] w_imm12;
    logic [XLEN-1:0] w_dt;
    logic            w_unused_bits;

    logic w_add, w_sub, w_and, w_orr;
    logic w_addi, w_subi, w_andi, w_orri;
    logic w_ldur, w_stur, w_cbz;

    assign w_op    = i_instr[31:21];
    assign w_imm12 = {{(XLEN-12){1'b0}}, i_instr[21:10]};
    assign w_dt    = {{(XLEN-9){i_instr[20]}}, i_instr[20:12]};

    // Rd/Rt/Rn fields are resolved by the register file upstream
    assign w_unused_bits = ^i_instr[9:0];

    assign w_add  = op_hit(w_op, OP_ADD,  M_FULL);
    assign w_sub  = op_hit(w_op, OP_SUB,  M_FULL);
    assign w_and  = op_hit(w_op, OP_AND,  M_FULL);
    assign w_orr  = op_hit(w_op, OP_ORR,  M_FULL);
    assign w_addi = op_hit(w_op, OP_ADDI, M_IMM);
    assign w_subi = op_hit(w_op, OP_SUBI, M_IMM);
    assign w_andi = op_hit(w_op, OP_ANDI, M_IMM);
    assign w_orri = op_hit(w_op, OP_ORRI, M_IMM);
    assign w_ldur = op_hit(w_op, OP_LDUR, M_FULL);
    assign w_stur = op_hit(w_op, OP_STUR, M_FULL);
    assign w_cbz  = op_hit(w_op, OP_CBZ,  M_CBZ);

    // One-hot opcode match selects operands and ALU function
    always_comb begin
        o_payload = '0;
        o_illegal = 1'b0;
        unique case (1'b1)
            w_add: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = i_rm;
                o_payload.alu_select = SEL_ADD;
            end
            w_sub: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = i_rm;
                o_payload.alu_select = SEL_SUB;
            end
            w_and: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = i_rm;
                o_payload.alu_select = SEL_AND;
            end
            w_orr: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = i_rm;
                o_payload.alu_select = SEL_OR;
            end
            w_addi: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = w_imm12;
                o_payload.alu_select = SEL_ADD;
            end
            w_subi: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = w_imm12;
                o_payload.alu_select = SEL_SUB;
            end
            w_andi: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = w_imm12;
                o_payload.alu_select = SEL_AND;
            end
            w_orri: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = w_imm12;
                o_payload.alu_select = SEL_OR;
            end
            w_ldur, w_stur: begin
                o_payload.alu_a      = i_rn;
                o_payload.alu_b      = w_dt;
                o_payload.alu_select = SEL_ADD;
                o_payload.is_mem     = 1'b1;
            end
            w_cbz: begin
                o_payload.alu_a      = i_rm;
                o_payload.alu_b      = '0;
                o_payload.alu_select = SEL_ADD;
                o_payload.is_cbz     = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/legv8_alu_issue.sv
// LEGv8 execute-issue stage: decode, 2-entry skid buffer with a
// registered ready, and a saturating illegal-opcode counter.
module legv8_alu_issue
    import legv8_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_rn_data,
    input  logic [DATA_W-1:0] i_rm_data,
    input  logic              i_flush,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [1:0]        o_alu_select,
    output logic              o_is_mem,
    output logic              o_is_cbz,
    output logic [CNT_W-1:0]  o_illegal_cnt
);

    issue_t           w_dec;
    logic             w_illegal;
    logic             w_accept;
    logic             w_push;
    logic             w_main_free;
    logic             w_skid_v_nxt;

    issue_t           r_main;
    issue_t           r_skid;
    logic             r_main_v;
    logic             r_skid_v;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    legv8_issue_decode u_dec (
        .i_instr   (i_instr),
        .i_rn      (i_rn_data),
        .i_rm      (i_rm_data),
        .o_payload (w_dec),
        .o_illegal (w_illegal)
    );

    assign w_accept    = i_in_valid && r_in_ready;
    assign w_push      = w_accept && !w_illegal;
    assign w_main_free = !r_main_v || i_out_ready;

    // Skid holds an entry only while main is stuck and a push arrives
    always_comb begin
        w_skid_v_nxt = 1'b0;
        if (!w_main_free) begin
            w_skid_v_nxt = r_skid_v || w_push;
        end
    end

    // Main/skid registers; skid refills main whenever main drains
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (i_flush) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_main_free) begin
                if (r_skid_v) begin
                    r_main   <= r_skid;
                    r_main_v <= 1'b1;
                end else if (w_push) begin
                    r_main   <= w_dec;
                    r_main_v <= 1'b1;
                end else begin
                    r_main_v <= 1'b0;
                end
            end else if (w_push) begin
                r_skid <= w_dec;
            end
            r_skid_v   <= w_skid_v_nxt;
            r_in_ready <= !w_skid_v_nxt;
        end
    end

    // Saturating count of accepted-but-dropped illegal words
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (!i_flush && w_accept && w_illegal
                     && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_main_v;
    assign o_alu_a       = r_main.alu_a;
    assign o_alu_b       = r_main.alu_b;
    assign o_alu_select  = r_main.alu_select;
    assign o_is_mem      = r_main.is_mem;
    assign o_is_cbz      = r_main.is_cbz;
    assign o_illegal_cnt = r_cnt;

endmodule

// File: tb/tb_legv8_alu_issue.sv
// Directed bench for legv8_alu_issue: decode, skid buffer,
// illegal counter, flush and reset behaviour.
module tb_legv8_alu_issue;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [DW-1:0] rn_data;
    logic [DW-1:0] rm_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_select;
    logic          is_mem;
    logic          is_cbz;
    logic [CW-1:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    legv8_alu_issue #(.DATA_W(DW), .CNT_W(CW)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_instr       (instr),
        .i_rn_data     (rn_data),
        .i_rm_data     (rm_data),
        .i_flush       (flush),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_select  (alu_select),
        .o_is_mem      (is_mem),
        .o_is_cbz      (is_cbz),
        .o_illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [10:0] op);
        return {op, 21'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [9:0] op,
                                          input logic [11:0] imm);
        return {op, imm, 10'd0};
    endfunction

    function automatic logic [31:0] dtype(input logic [10:0] op,
                                          input logic [8:0] dt);
        return {op, dt, 12'd0};
    endfunction

    // Advance one edge and settle past it before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %0b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        checks++;
        if (illegal_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", illegal_cnt);
        end
        checks++;
        if ({alu_a, alu_b, alu_select, is_mem, is_cbz} !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%0h b=%0h want 0",
                     alu_a, alu_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = rtype(11'b10001011000);
        rn_data   = 32'd5;
        rm_data   = 32'd3;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, alu_a, alu_b, alu_select}
            !== {1'b1, 32'd5, 32'd3, 2'b10}) begin
            errors++;
            $display("FAIL add: got v=%0b a=%0h b=%0h s=%0b want 1 5 3 10",
                     out_valid, alu_a, alu_b, alu_select);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_imm();
        logic [31:0] iw [6];
        logic [31:0] eb [6];
        logic [1:0]  es [6];
        logic        em [6];
        iw[0] = itype(10'b1001000100, 12'hFFF);
        eb[0] = 32'h0000_0FFF; es[0] = 2'b10; em[0] = 1'b0;
        iw[1] = dtype(11'b11111000010, 9'h1F0);
        eb[1] = 32'hFFFF_FFF0; es[1] = 2'b10; em[1] = 1'b1;
        iw[2] = itype(10'b1101000100, 12'h010);
        eb[2] = 32'h0000_0010; es[2] = 2'b11; em[2] = 1'b0;
        iw[3] = itype(10'b1001001000, 12'h0F0);
        eb[3] = 32'h0000_00F0; es[3] = 2'b00; em[3] = 1'b0;
        iw[4] = itype(10'b1011001000, 12'h800);
        eb[4] = 32'h0000_0800; es[4] = 2'b01; em[4] = 1'b0;
        iw[5] = dtype(11'b11111000000, 9'h00F);
        eb[5] = 32'h0000_000F; es[5] = 2'b10; em[5] = 1'b1;
        out_ready = 1'b1;
        rn_data   = 32'd1;
        rm_data   = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            instr    = iw[i];
            step();
            checks++;
            if ({out_valid, alu_a, alu_b, alu_select, is_mem}
                !== {1'b1, 32'd1, eb[i], es[i], em[i]}) begin
                errors++;
                $display("FAIL imm%0d: got v=%0b a=%0h b=%0h s=%0b m=%0b want 1 1 %0h %0b %0b",
                         i, out_valid, alu_a, alu_b, alu_select, is_mem,
                         eb[i], es[i], em[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = rtype(11'b10001010000);
        rn_data   = 32'h0F0F;
        rm_data   = 32'h00FF;
        step();
        instr   = rtype(11'b10101010000);
        rn_data = 32'h1111;
        rm_data = 32'h2222;
        step();
        checks++;
        if ({in_ready, out_valid, alu_a, alu_select}
            !== {1'b0, 1'b1, 32'h0F0F, 2'b00}) begin
            errors++;
            $display("FAIL b2b_full: got rdy=%0b v=%0b a=%0h s=%0b want 0 1 f0f 00",
                     in_ready, out_valid, alu_a, alu_select);
        end
        instr   = rtype(11'b11001011000);
        rn_data = 32'd100;
        rm_data = 32'd30;
        step();
        checks++;
        if ({in_ready, alu_a, alu_b, alu_select}
            !== {1'b0, 32'h0F0F, 32'h00FF, 2'b00}) begin
            errors++;
            $display("FAIL b2b_hold: got rdy=%0b a=%0h b=%0h s=%0b want 0 f0f ff 00",
                     in_ready, alu_a, alu_b, alu_select);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, alu_a, alu_b, alu_select}
            !== {1'b1, 1'b1, 32'h1111, 32'h2222, 2'b01}) begin
            errors++;
            $display("FAIL b2b_orr: got rdy=%0b v=%0b a=%0h b=%0h s=%0b want 1 1 1111 2222 01",
                     in_ready, out_valid, alu_a, alu_b, alu_select);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, alu_a, alu_b, alu_select}
            !== {1'b1, 32'd100, 32'd30, 2'b11}) begin
            errors++;
            $display("FAIL b2b_sub: got v=%0b a=%0h b=%0h s=%0b want 1 64 1e 11",
                     out_valid, alu_a, alu_b, alu_select);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_nodup: got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'd0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({out_valid, illegal_cnt} !== {1'b0, 4'd3}) begin
            errors++;
            $display("FAIL illegal_drop: got v=%0b cnt=%0d want 0 3",
                     out_valid, illegal_cnt);
        end
        instr   = {8'b10110100, 24'h00_0123};
        rn_data = 32'h1234;
        rm_data = 32'd0;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, alu_a, alu_b, alu_select, is_cbz, is_mem,
             illegal_cnt}
            !== {1'b1, 32'd0, 32'd0, 2'b10, 1'b1, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL cbz: got v=%0b a=%0h b=%0h s=%0b z=%0b m=%0b cnt=%0d want 1 0 0 10 1 0 3",
                     out_valid, alu_a, alu_b, alu_select, is_cbz, is_mem,
                     illegal_cnt);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = rtype(11'b10001011000);
        rn_data   = 32'd1;
        rm_data   = 32'd1;
        step();
        instr = rtype(11'b10101010000);
        step();
        instr   = itype(10'b1001000100, 12'h007);
        rn_data = 32'd9;
        flush   = 1'b1;
        step();
        checks++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_clear: got v=%0b rdy=%0b want 0 1",
                     out_valid, in_ready);
        end
        instr = 32'd0;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (illegal_cnt !== 4'd3) begin
            errors++;
            $display("FAIL flush_nocount: got cnt=%0d want 3", illegal_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped: got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'd0;
        for (int i = 0; i < 16; i++) step();
        in_valid = 1'b0;
        checks++;
        if ({illegal_cnt, out_valid} !== {4'd15, 1'b0}) begin
            errors++;
            $display("FAIL saturate: got cnt=%0d v=%0b want 15 0",
                     illegal_cnt, out_valid);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = rtype(11'b11001011000);
        rn_data   = 32'd7;
        rm_data   = 32'd2;
        step();
        step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready, illegal_cnt, alu_a}
            !== {1'b0, 1'b1, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b rdy=%0b cnt=%0d a=%0h want 0 1 0 0",
                     out_valid, in_ready, illegal_cnt, alu_a);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_empty: got v=%0b want 0", out_valid);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'd0;
        rn_data   = '0;
        rm_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_imm();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
